// File: rtl/mutex_client_ctrl.sv
// Core-side client of a hardware mutex: turns core lock/unlock requests into mutex pulses and responses.
// Optional wait-cycle counter enabled by defining MUTEX_CLIENT_WAIT_CNT_EN.
module mutex_client_ctrl #(
  parameter int MUTEX_MSG_W = 32,
  parameter int WAIT_CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   core_req_i,
  input  logic                   core_op_i,
  input  logic [MUTEX_MSG_W-1:0] core_wdata_i,
  output logic                   core_gnt_o,
  output logic                   core_rvalid_o,
  output logic [MUTEX_MSG_W-1:0] core_rdata_o,
  output logic                   core_err_o,
  output logic                   lock_req_o,
  output logic                   unlock_req_o,
  output logic [MUTEX_MSG_W-1:0] mutex_msg_wdata_o,
  input  logic [MUTEX_MSG_W-1:0] mutex_msg_rdata_i,
  input  logic                   mutex_event_i,
  output logic [WAIT_CNT_W-1:0]  wait_cycles_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EVT,
    MSG_RD,
    OWNED
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_rvalid;
  logic                     r_err;
  logic [MUTEX_MSG_W-1:0]   r_rdata;
  logic                     w_gnt;
  logic                     w_lock;
  logic                     w_unlock;
  logic                     w_resp_zero;
  logic                     w_resp_err;
  logic                     w_load_msg;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_lock      = 1'b0;
    w_unlock    = 1'b0;
    w_resp_zero = 1'b0;
    w_resp_err  = 1'b0;
    w_load_msg  = 1'b0;
    case (r_state)
      IDLE: begin
        if (core_req_i) begin
          w_gnt = 1'b1;
          if (!core_op_i) begin
            w_lock      = 1'b1;
            w_state_nxt = mutex_event_i ? MSG_RD : WAIT_EVT;
          end else begin
            w_resp_zero = 1'b1;
            w_resp_err  = 1'b1;
          end
        end
      end
      WAIT_EVT: begin
        if (mutex_event_i) w_state_nxt = MSG_RD;
      end
      MSG_RD: begin
        // The mutex message register is valid one cycle after the grant event.
        w_load_msg  = 1'b1;
        w_state_nxt = OWNED;
      end
      OWNED: begin
        if (core_req_i) begin
          w_gnt       = 1'b1;
          w_resp_zero = 1'b1;
          if (core_op_i) begin
            w_unlock    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_resp_err  = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= w_load_msg | w_resp_zero;
      r_err    <= w_resp_err;
      if (w_load_msg) begin
        r_rdata <= mutex_msg_rdata_i;
      end else if (w_resp_zero) begin
        r_rdata <= '0;
      end
    end
  end

  // Combinational handshakes are forced low while reset is held, even if a request is pending.
  assign core_gnt_o        = w_gnt & ~rst_i;
  assign lock_req_o        = w_lock & ~rst_i;
  assign unlock_req_o      = w_unlock & ~rst_i;
  assign mutex_msg_wdata_o = unlock_req_o ? core_wdata_i : '0;
  assign core_rvalid_o     = r_rvalid;
  assign core_err_o        = r_err;
  assign core_rdata_o      = r_rdata;

`ifdef MUTEX_CLIENT_WAIT_CNT_EN
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] r_wait_cycles;
  logic [WAIT_CNT_W-1:0] w_wait_inc;

  assign w_wait_inc = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + WAIT_CNT_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt    <= '0;
      r_wait_cycles <= '0;
    end else begin
      if (w_lock) begin
        r_wait_cnt <= '0;
      end else if (r_state == WAIT_EVT) begin
        r_wait_cnt <= w_wait_inc;
      end
      // The event cycle itself counts as a waiting cycle.
      if (w_lock && mutex_event_i) begin
        r_wait_cycles <= '0;
      end else if (r_state == WAIT_EVT && mutex_event_i) begin
        r_wait_cycles <= w_wait_inc;
      end
    end
  end

  assign wait_cycles_o = r_wait_cycles;
`else
  assign wait_cycles_o = '0;
`endif

`ifdef SIM
  logic w_spurious_evt;
  assign w_spurious_evt = mutex_event_i & ~((r_state == WAIT_EVT) | w_lock);
`endif

endmodule

// File: tb/tb_mutex_client_ctrl.sv
// Randomised scoreboard bench for mutex_client_ctrl; the bench also plays the mutex unit.
module tb_mutex_client_ctrl;
  localparam int MW    = 32;
  localparam int CW    = 4;
  localparam int MAX_D = 20;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          core_req_i = 1'b0;
  logic          core_op_i = 1'b0;
  logic [MW-1:0] core_wdata_i = '0;
  logic          core_gnt_o;
  logic          core_rvalid_o;
  logic [MW-1:0] core_rdata_o;
  logic          core_err_o;
  logic          lock_req_o;
  logic          unlock_req_o;
  logic [MW-1:0] mutex_msg_wdata_o;
  logic [MW-1:0] mutex_msg_rdata_i = '0;
  logic          mutex_event_i = 1'b0;
  logic [CW-1:0] wait_cycles_o;

  mutex_client_ctrl #(.MUTEX_MSG_W(MW), .WAIT_CNT_W(CW)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .core_req_i        (core_req_i),
    .core_op_i         (core_op_i),
    .core_wdata_i      (core_wdata_i),
    .core_gnt_o        (core_gnt_o),
    .core_rvalid_o     (core_rvalid_o),
    .core_rdata_o      (core_rdata_o),
    .core_err_o        (core_err_o),
    .lock_req_o        (lock_req_o),
    .unlock_req_o      (unlock_req_o),
    .mutex_msg_wdata_o (mutex_msg_wdata_o),
    .mutex_msg_rdata_i (mutex_msg_rdata_i),
    .mutex_event_i     (mutex_event_i),
    .wait_cycles_o     (wait_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int            cyc;
    logic [MW-1:0] data;
    logic          err;
    logic [CW-1:0] wait_v;
  } resp_t;

  resp_t         exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  bit            owned = 1'b0;
  int            busy_until = 0;
  logic [CW-1:0] last_wait = '0;
  logic [MW-1:0] last_rdata = '0;
  int            plan_d = 0;
  logic [MW-1:0] plan_msg = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [CW-1:0] sat(input int d);
`ifdef MUTEX_CLIENT_WAIT_CNT_EN
    return (d > (1 << CW) - 1) ? {CW{1'b1}} : CW'(d);
`else
    return '0;
`endif
  endfunction

  // Mutex unit: answers lock pulses with a grant event after plan_d cycles, message one cycle later.
  initial begin
    bit            pending = 1'b0;
    bit            msg_due = 1'b0;
    int            cnt = 0;
    logic [MW-1:0] msg = '0;
    forever begin
      @(posedge clk_i);
      #2;
      mutex_event_i     = 1'b0;
      mutex_msg_rdata_i = msg_due ? msg : MW'($urandom);
      msg_due           = 1'b0;
      if (rst_i) begin
        pending = 1'b0;
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          mutex_event_i = 1'b1;
          pending       = 1'b0;
          msg_due       = 1'b1;
        end
      end else if (lock_req_o) begin
        msg = plan_msg;
        if (plan_d == 0) begin
          mutex_event_i = 1'b1;
          msg_due       = 1'b1;
        end else begin
          pending = 1'b1;
          cnt     = plan_d;
        end
      end else if (!core_req_i && $urandom_range(0, 7) == 0) begin
        mutex_event_i = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every response and polices idle-time outputs.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk_i);
      if (mon_en && !rst_i) begin
        if (!unlock_req_o) check("wdata_when_no_unlock", mutex_msg_wdata_o, 0);
        if (!core_req_i) check("pulses_without_req", {core_gnt_o, lock_req_o, unlock_req_o}, 0);
        if (core_rvalid_o) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_rvalid");
          end else begin
            r = exp_q.pop_front();
            check("resp_cycle", cyc, r.cyc);
            check("resp_data", core_rdata_o, r.data);
            check("resp_err", core_err_o, r.err);
            check("wait_cycles", wait_cycles_o, r.wait_v);
            last_rdata = r.data;
          end
        end else begin
          check("rdata_hold", core_rdata_o, last_rdata);
        end
      end
    end
  end

  // data is the unlock message for op=1 and the mutex message for op=0.
  task automatic do_req(input bit op, input int d, input logic [MW-1:0] data);
    resp_t r;
    int    n = 0;
    bit    done = 1'b0;
    bit    exp_lock;
    bit    exp_unlock;
    plan_d   = d;
    plan_msg = data;
    @(posedge clk_i);
    #1;
    core_req_i   = 1'b1;
    core_op_i    = op;
    core_wdata_i = data;
    while (!done) begin
      @(negedge clk_i);
      check("gnt", core_gnt_o, 64'(cyc >= busy_until));
      if (core_gnt_o) begin
        exp_lock   = !op && !owned;
        exp_unlock = op && owned;
        check("lock_req", lock_req_o, exp_lock);
        check("unlock_req", unlock_req_o, exp_unlock);
        check("msg_wdata", mutex_msg_wdata_o, exp_unlock ? data : '0);
        if (exp_lock) begin
          last_wait  = sat(d);
          r.cyc      = cyc + d + 2;
          r.data     = data;
          r.err      = 1'b0;
          busy_until = cyc + d + 2;
          owned      = 1'b1;
        end else begin
          r.cyc  = cyc + 1;
          r.data = '0;
          r.err  = !exp_unlock;
          if (exp_unlock) owned = 1'b0;
        end
        r.wait_v = last_wait;
        exp_q.push_back(r);
        done = 1'b1;
      end else begin
        check("stall_no_pulse", {lock_req_o, unlock_req_o}, 0);
        n++;
        if (n > MAX_D + 10) begin
          fail_now("gnt_timeout");
          done = 1'b1;
        end else begin
          @(posedge clk_i);
          #1;
        end
      end
    end
    @(posedge clk_i);
    #1;
    core_req_i   = 1'b0;
    core_op_i    = 1'($urandom);
    core_wdata_i = MW'($urandom);
    repeat ($urandom_range(0, 3)) @(posedge clk_i);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, core_gnt_o, 0);
    check({tag, "_rvalid"}, core_rvalid_o, 0);
    check({tag, "_err"}, core_err_o, 0);
    check({tag, "_lock"}, lock_req_o, 0);
    check({tag, "_unlock"}, unlock_req_o, 0);
    check({tag, "_rdata"}, core_rdata_o, 0);
    check({tag, "_wdata"}, mutex_msg_wdata_o, 0);
    check({tag, "_wait"}, wait_cycles_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // A request held during reset must still see every output low.
    rst_i        = 1'b1;
    core_req_i   = 1'b1;
    core_op_i    = 1'b1;
    core_wdata_i = '1;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i);
    #1;
    core_req_i = 1'b0;
    rst_i      = 1'b0;
    mon_en     = 1'b1;

    do_req(1'b0, 0, 32'hA5A5_A5A5);
    do_req(1'b1, 0, 32'h1234_5678);
    do_req(1'b1, 0, MW'($urandom));
    do_req(1'b0, 5, MW'($urandom));
    do_req(1'b0, 0, MW'($urandom));
    do_req(1'b1, 0, MW'($urandom));
    do_req(1'b0, MAX_D, MW'($urandom));
    do_req(1'b1, 0, MW'($urandom));
    do_req(1'b0, 15, MW'($urandom));
    do_req(1'b0, 1, MW'($urandom));

    for (int i = 0; i < 80; i++) begin
      do_req(1'($urandom), $urandom_range(0, MAX_D), MW'($urandom));
    end

    // Reset while waiting for the grant event drops the pending lock silently.
    if (owned) do_req(1'b1, 0, MW'($urandom));
    do_req(1'b0, MAX_D, MW'($urandom));
    @(posedge clk_i);
    #1;
    core_req_i = 1'b1;
    core_op_i  = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    owned      = 1'b0;
    busy_until = 0;
    last_wait  = '0;
    last_rdata = '0;
    @(posedge clk_i);
    #1;
    core_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    do_req(1'b0, 3, MW'($urandom));
    do_req(1'b1, 0, MW'($urandom));

    repeat (4) @(negedge clk_i);
    check("responses_outstanding", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
